mem_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the CPU memory bus (a/d/we/rd/spo/ready protocol). Master 0 is the multicycle core. Master 1 is a secondary bus master such as DMA or a debug loader. The block shares the single memory/MMIO bus between them. It forwards uncontended requests combinationally, so the core keeps zero-wait accesses, and it latches a losing request until the bus is free.

---
 rtl/mem_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for the a/d/we/rd/spo/ready memory bus.
// Uncontended requests pass straight through; a losing request waits in a per-master pending register.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_a,
    input  logic [DATA_W-1:0] m0_d,
    input  logic              m0_we,
    input  logic              m0_rd,
    output logic [DATA_W-1:0] m0_spo,
    output logic              m0_ready,
    input  logic [ADDR_W-1:0] m1_a,
    input  logic [DATA_W-1:0] m1_d,
    input  logic              m1_we,
    input  logic              m1_rd,
    output logic [DATA_W-1:0] m1_spo,
    output logic              m1_ready,
    output logic [ADDR_W-1:0] s_a,
    output logic [DATA_W-1:0] s_d,
    output logic              s_we,
    output logic              s_rd,
    input  logic [DATA_W-1:0] s_spo,
    input  logic              s_ready,
    output logic              grant,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WAIT0, WAIT1} state_t;

    state_t state, state_next;

    logic              p0_valid, p0_we, p1_valid, p1_we;
    logic [ADDR_W-1:0] p0_a, p1_a, hold_a;
    logic [DATA_W-1:0] p0_d, p1_d, hold_d;
    logic              grant_q, last;
    logic              req0, req1, cand0, cand1, win;
    logic              issue, lat0, lat1;

    // A pulse from a master that already has something outstanding is ignored.
    assign req0  = (m0_rd | m0_we) && !p0_valid && (state != WAIT0);
    assign req1  = (m1_rd | m1_we) && !p1_valid && (state != WAIT1);
    assign cand0 = req0 | p0_valid;
    assign cand1 = req1 | p1_valid;
    assign win   = (cand0 && cand1) ? ((ROUND_ROBIN != 0) ? ~last : 1'b0) : cand1;

    assign m0_spo = s_spo;
    assign m1_spo = s_spo;
    assign grant  = grant_q & ~rst;
    assign busy   = ~rst & (state != IDLE);

    always_comb begin
        state_next = state;
        s_a        = hold_a;
        s_d        = hold_d;
        s_we       = 1'b0;
        s_rd       = 1'b0;
        m0_ready   = 1'b1;
        m1_ready   = 1'b1;
        issue      = 1'b0;
        lat0       = 1'b0;
        lat1       = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (cand0 || cand1) begin
                        issue = 1'b1;
                        if (!win) begin
                            if (p0_valid) begin
                                s_a  = p0_a;
                                s_d  = p0_d;
                                s_we = p0_we;
                                s_rd = ~p0_we;
                            end else begin
                                s_a  = m0_a;
                                s_d  = m0_d;
                                s_we = m0_we;
                                s_rd = m0_rd & ~m0_we;
                            end
                            m0_ready = s_ready;
                            m1_ready = ~cand1;
                            lat1     = req1;
                            if (!s_ready) state_next = WAIT0;
                        end else begin
                            if (p1_valid) begin
                                s_a  = p1_a;
                                s_d  = p1_d;
                                s_we = p1_we;
                                s_rd = ~p1_we;
                            end else begin
                                s_a  = m1_a;
                                s_d  = m1_d;
                                s_we = m1_we;
                                s_rd = m1_rd & ~m1_we;
                            end
                            m1_ready = s_ready;
                            m0_ready = ~cand0;
                            lat0     = req0;
                            if (!s_ready) state_next = WAIT1;
                        end
                    end
                end
                WAIT0: begin
                    m0_ready = s_ready;
                    m1_ready = ~cand1;
                    lat1     = req1;
                    if (s_ready) state_next = IDLE;
                end
                WAIT1: begin
                    m1_ready = s_ready;
                    m0_ready = ~cand0;
                    lat0     = req0;
                    if (s_ready) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Reset abandons any in-flight or pending transaction; last=1 lets master 0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            p0_valid <= 1'b0;
            p0_we    <= 1'b0;
            p0_a     <= '0;
            p0_d     <= '0;
            p1_valid <= 1'b0;
            p1_we    <= 1'b0;
            p1_a     <= '0;
            p1_d     <= '0;
            hold_a   <= '0;
            hold_d   <= '0;
            grant_q  <= 1'b0;
            last     <= 1'b1;
        end else begin
            state <= state_next;
            if (issue) begin
                grant_q <= win;
                last    <= win;
                hold_a  <= s_a;
                hold_d  <= s_d;
                if (!win) p0_valid <= 1'b0;
                else      p1_valid <= 1'b0;
            end
            if (lat0) begin
                p0_valid <= 1'b1;
                p0_a     <= m0_a;
                p0_d     <= m0_d;
                p0_we    <= m0_we;
            end
            if (lat1) begin
                p1_valid <= 1'b1;
                p1_a     <= m1_a;
                p1_d     <= m1_d;
                p1_we    <= m1_we;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a cycle-by-cycle vector table on a round-robin instance,
// then a fixed-priority instance driven through repeated contention with a scoreboard.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_a, m0_d, m1_a, m1_d, s_spo;
    logic        m0_we, m0_rd, m1_we, m1_rd, s_ready;

    logic [31:0] m0_spo, m1_spo, s_a, s_d;
    logic        m0_ready, m1_ready, s_we, s_rd, grant, busy;
    logic [31:0] fp_m0_spo, fp_m1_spo, fp_s_a, fp_s_d;
    logic        fp_m0_ready, fp_m1_ready, fp_s_we, fp_s_rd, fp_grant, fp_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst, m0_rd, m0_we;
        logic [31:0] m0_a, m0_d;
        logic        m1_rd, m1_we;
        logic [31:0] m1_a, m1_d;
        logic        s_ready;
        logic [31:0] s_spo;
        logic        x_rd, x_we, x_chk;
        logic [31:0] x_a, x_d;
        logic        x_r0, x_r1, x_busy, x_grant;
    } vec_t;

    vec_t        tbl[$];
    vec_t        exp_q[$];
    logic [31:0] sb_q[$];

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd), .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd), .m1_spo(m1_spo), .m1_ready(m1_ready),
        .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready),
        .grant(grant), .busy(busy)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd), .m0_spo(fp_m0_spo), .m0_ready(fp_m0_ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd), .m1_spo(fp_m1_spo), .m1_ready(fp_m1_ready),
        .s_a(fp_s_a), .s_d(fp_s_d), .s_we(fp_s_we), .s_rd(fp_s_rd), .s_spo(s_spo), .s_ready(s_ready),
        .grant(fp_grant), .busy(fp_busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic a0rd, input logic a0we, input logic [31:0] a0, input logic [31:0] d0,
        input logic a1rd, input logic a1we, input logic [31:0] a1, input logic [31:0] d1,
        input logic rdy, input logic [31:0] spo,
        input logic xrd, input logic xwe, input logic xchk, input logic [31:0] xa, input logic [31:0] xd,
        input logic xr0, input logic xr1, input logic xbusy, input logic xgrant);
        vec_t v;
        v.rst = r;      v.m0_rd = a0rd; v.m0_we = a0we; v.m0_a = a0; v.m0_d = d0;
        v.m1_rd = a1rd; v.m1_we = a1we; v.m1_a = a1;    v.m1_d = d1;
        v.s_ready = rdy; v.s_spo = spo;
        v.x_rd = xrd; v.x_we = xwe; v.x_chk = xchk; v.x_a = xa; v.x_d = xd;
        v.x_r0 = xr0; v.x_r1 = xr1; v.x_busy = xbusy; v.x_grant = xgrant;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle(input logic r, input logic rdy);
        rst = r; s_ready = rdy; s_spo = 32'h0;
        m0_rd = 0; m0_we = 0; m0_a = 0; m0_d = 0;
        m1_rd = 0; m1_we = 0; m1_a = 0; m1_d = 0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        rst = v.rst;
        m0_rd = v.m0_rd; m0_we = v.m0_we; m0_a = v.m0_a; m0_d = v.m0_d;
        m1_rd = v.m1_rd; m1_we = v.m1_we; m1_a = v.m1_a; m1_d = v.m1_d;
        s_ready = v.s_ready; s_spo = v.s_spo;
        exp_q.push_back(v);
    endtask

    task automatic check_output(input int idx);
        vec_t e;
        #2;
        e = exp_q.pop_front();
        chk("s_rd",     idx, {31'b0, s_rd},     {31'b0, e.x_rd});
        chk("s_we",     idx, {31'b0, s_we},     {31'b0, e.x_we});
        chk("m0_ready", idx, {31'b0, m0_ready}, {31'b0, e.x_r0});
        chk("m1_ready", idx, {31'b0, m1_ready}, {31'b0, e.x_r1});
        chk("busy",     idx, {31'b0, busy},     {31'b0, e.x_busy});
        chk("grant",    idx, {31'b0, grant},    {31'b0, e.x_grant});
        chk("m0_spo",   idx, m0_spo, e.s_spo);
        chk("m1_spo",   idx, m1_spo, e.s_spo);
        if (e.x_chk) begin
            chk("s_a", idx, s_a, e.x_a);
            chk("s_d", idx, s_d, e.x_d);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        drive_idle(1'b1, 1'b1);

        // reset and the cycle after
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));
        // zero-wait read by m0
        tbl.push_back(mk(0, 1,0,32'hF0000000,0, 0,0,0,0, 1,32'h13000000, 1,0,1,32'hF0000000,0, 1,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));
        // m0 read with three wait cycles
        tbl.push_back(mk(0, 1,0,32'h1000,0, 0,0,0,0, 0,0, 1,0,1,32'h1000,0, 0,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,1,32'h1000,0, 0,1,1,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,1,32'h1000,0, 0,1,1,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,32'hDEADBEEF, 0,0,1,32'h1000,0, 1,1,1,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));
        // round-robin contention from a fresh reset
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(0, 0,1,32'h100,32'h11, 1,0,32'h200,0, 1,0, 0,1,1,32'h100,32'h11, 1,0,0,0));
        tbl.push_back(mk(0, 0,1,32'h104,32'h12, 1,0,32'h200,0, 1,0, 1,0,1,32'h200,0, 0,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,1,1,32'h104,32'h12, 1,1,0,1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(0, 0,1,32'h100,32'h11, 1,0,32'h200,0, 1,32'h55, 1,0,1,32'h200,0, 0,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,1,1,32'h100,32'h11, 1,1,0,1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));
        // m0 arrives while m1 waits on the slave
        tbl.push_back(mk(0, 0,0,0,0, 1,0,32'h300,0, 0,0, 1,0,1,32'h300,0, 1,0,0,0));
        tbl.push_back(mk(0, 1,0,32'h400,0, 0,0,0,0, 0,0, 0,0,1,32'h300,0, 0,0,1,1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,1,32'h300,0, 0,0,1,1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,32'hCAFE0001, 0,0,1,32'h300,0, 0,1,1,1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 1,0,1,32'h400,0, 1,1,0,1));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));
        // reset during WAIT0 with m1 pending, then a late s_ready
        tbl.push_back(mk(0, 1,0,32'h500,0, 0,0,0,0, 0,0, 1,0,1,32'h500,0, 0,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,1,32'h600,32'h66, 0,0, 0,0,1,32'h500,0, 0,0,1,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0, 0,0,0,0,0, 1,1,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i]);
            check_output(i);
        end

        // fixed priority: m0 always first, every m1 request completes afterwards
        @(negedge clk);
        drive_idle(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bit found;
            @(negedge clk);
            drive_idle(1'b0, (i % 2) == 0);
            m0_rd = 1; m0_a = 32'h1000 + i;
            m1_rd = 1; m1_a = 32'h2000 + i;
            sb_q.push_back(32'h2000 + i);
            #2;
            chk("fp_first_rd",    100 + i, {31'b0, fp_s_rd}, 32'h1);
            chk("fp_first_a",     100 + i, fp_s_a, 32'h1000 + i);
            chk("fp_m0_ready",    100 + i, {31'b0, fp_m0_ready}, {31'b0, s_ready});
            chk("fp_m1_held",     100 + i, {31'b0, fp_m1_ready}, 32'h0);
            found = 0;
            for (int c = 0; c < 6 && !found; c++) begin
                @(negedge clk);
                drive_idle(1'b0, 1'b1);
                #2;
                if (fp_s_rd) begin
                    found = 1;
                    chk("fp_m1_a",     100 + i, fp_s_a, sb_q.pop_front());
                    chk("fp_m1_ready", 100 + i, {31'b0, fp_m1_ready}, 32'h1);
                end
            end
            if (!found) begin
                checks++;
                errors++;
                $display("[TB] FAIL fp_m1_timeout step %0d: got no m1 issue expected issue within 6 cycles", 100 + i);
                void'(sb_q.pop_front());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
